multicycle_ctrl_fsm: RTL and testbench

- Main control FSM for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Drives the register, PC, memory and ALU select/enable lines.
- Generates the ALU `sub_sra` control for OP, OP-IMM and BRANCH classes, and halts on SYSTEM or illegal opcodes.

---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl_fsm.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle RV32I control FSM and its datapath.
// The FSM side uses the master modport; the datapath (or bench) uses slave.
interface multicycle_ctrl_if;
    logic        start;
    logic [31:0] insn;
    logic        mem_ready;
    logic        branch_taken;
    logic [2:0]  state;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic        sub_sra;
    logic        halted;
    logic        illegal;

    modport master (
        input  start, insn, mem_ready, branch_taken,
        output state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
               rf_we, wb_sel, alu_a_sel, alu_b_sel, sub_sra, halted, illegal
    );

    modport slave (
        output start, insn, mem_ready, branch_taken,
        input  state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
               rf_we, wb_sel, alu_a_sel, alu_b_sel, sub_sra, halted, illegal
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core: FETCH, DECODE, EXEC, MEM, WB
// for one instruction at a time, halting on SYSTEM or unknown opcodes.
module multicycle_ctrl_fsm #(
    parameter bit RESET_TO_FETCH = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE,
        C_OPIMM, C_OP, C_FENCE, C_SYSTEM, C_ILLEGAL
    } cls_e;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       taken_q, taken_d;
    cls_e       cls;
    logic [2:0] funct3;
    logic       slt_like, sra_like, sub_sra_raw;
    logic       unused_insn_bits;

    assign unused_insn_bits = ^{bus.insn[31], bus.insn[29:15], bus.insn[11:7]};
    assign funct3 = bus.insn[14:12];

    always_comb begin
        unique case (bus.insn[6:0])
            7'b0110111: cls = C_LUI;
            7'b0010111: cls = C_AUIPC;
            7'b1101111: cls = C_JAL;
            7'b1100111: cls = C_JALR;
            7'b1100011: cls = C_BRANCH;
            7'b0000011: cls = C_LOAD;
            7'b0100011: cls = C_STORE;
            7'b0010011: cls = C_OPIMM;
            7'b0110011: cls = C_OP;
            7'b0001111: cls = C_FENCE;
            7'b1110011: cls = C_SYSTEM;
            default:    cls = C_ILLEGAL;
        endcase
    end

    // SLT/SLTU style compares and SRA/SRAI both need the ALU's subtract/arith path.
    assign slt_like = ~funct3[2] & funct3[1];
    assign sra_like = (funct3 == 3'b101) & bus.insn[30];

    always_comb begin
        unique case (cls)
            C_OPIMM:  sub_sra_raw = slt_like | sra_like;
            C_OP:     sub_sra_raw = ((funct3 == 3'b000) & bus.insn[30]) | slt_like | sra_like;
            C_BRANCH: sub_sra_raw = 1'b1;
            default:  sub_sra_raw = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (RESET_TO_FETCH) state_q <= S_FETCH;
            else                state_q <= S_HALT;
            illegal_q <= 1'b0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            taken_q   <= taken_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        taken_d   = taken_q;
        unique case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (cls == C_ILLEGAL) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else if (cls == C_SYSTEM) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                taken_d = bus.branch_taken;
                if (cls == C_LOAD || cls == C_STORE) state_d = S_MEM;
                else                                 state_d = S_WB;
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    if (cls == C_STORE) state_d = S_FETCH;
                    else                state_d = S_WB;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   if (bus.start) state_d = S_FETCH;
            default:  state_d = S_HALT;
        endcase
    end

    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr_sel = 1'b0;
        bus.ir_we        = 1'b0;
        bus.pc_we        = 1'b0;
        bus.pc_src       = 2'b00;
        bus.rf_we        = 1'b0;
        bus.wb_sel       = 2'b00;
        bus.alu_a_sel    = 1'b0;
        bus.alu_b_sel    = 1'b0;
        bus.sub_sra      = 1'b0;
        bus.halted       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.ir_we   = bus.mem_ready;
            end
            S_EXEC: begin
                bus.alu_a_sel = (cls == C_AUIPC) || (cls == C_JAL) || (cls == C_BRANCH);
                bus.alu_b_sel = (cls != C_OP);
                bus.sub_sra   = sub_sra_raw;
            end
            S_MEM: begin
                bus.mem_req      = 1'b1;
                bus.mem_addr_sel = 1'b1;
                bus.mem_we       = (cls == C_STORE);
                bus.pc_we        = (cls == C_STORE) & bus.mem_ready;
            end
            S_WB: begin
                bus.pc_we   = 1'b1;
                bus.sub_sra = sub_sra_raw;
                bus.rf_we   = !(cls == C_BRANCH || cls == C_FENCE || cls == C_STORE);
                unique case (cls)
                    C_LUI:         bus.wb_sel = 2'b11;
                    C_LOAD:        bus.wb_sel = 2'b01;
                    C_JAL, C_JALR: bus.wb_sel = 2'b10;
                    default:       bus.wb_sel = 2'b00;
                endcase
                unique case (cls)
                    C_JAL:    bus.pc_src = 2'b01;
                    C_BRANCH: bus.pc_src = taken_q ? 2'b01 : 2'b00;
                    C_JALR:   bus.pc_src = 2'b10;
                    default:  bus.pc_src = 2'b00;
                endcase
            end
            S_HALT:   bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.state   = state_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: table of instructions with
// hand-derived control expectations, plus reset/halt corner sequences.
module tb_multicycle_ctrl_fsm;

    localparam logic [2:0] ST_FETCH = 3'd0, ST_DEC = 3'd1, ST_EXEC = 3'd2,
                           ST_MEM = 3'd3, ST_WB = 3'd4, ST_HALT = 3'd7;

    typedef enum int {K_ALU, K_LOAD, K_STORE, K_HALT} kind_e;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic       sub_sra;
        logic       halted;
        logic       illegal;
    } outs_t;

    typedef struct {
        string       name;
        logic [31:0] insn;
        int          fetch_wait;
        int          mem_wait;
        logic        taken;
        kind_e       kind;
        logic        sets_illegal;
        logic        alu_a;
        logic        alu_b;
        logic        sub_sra;
        logic        rf_we;
        logic [1:0]  wb_sel;
        logic [1:0]  pc_src;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_h = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_illegal = 1'b0;
    outs_t exp_q[$];
    vec_t  vecs[18];
    vec_t  ecall_v;

    multicycle_ctrl_if dut_if ();
    multicycle_ctrl_if h_if ();

    multicycle_ctrl_fsm #(.RESET_TO_FETCH(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.master)
    );

    multicycle_ctrl_fsm #(.RESET_TO_FETCH(1'b0)) u_dut_halt (
        .clk   (clk),
        .reset (reset_h),
        .bus   (h_if.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic outs_t sample();
        outs_t s;
        s.state        = dut_if.state;
        s.mem_req      = dut_if.mem_req;
        s.mem_we       = dut_if.mem_we;
        s.mem_addr_sel = dut_if.mem_addr_sel;
        s.ir_we        = dut_if.ir_we;
        s.pc_we        = dut_if.pc_we;
        s.pc_src       = dut_if.pc_src;
        s.rf_we        = dut_if.rf_we;
        s.wb_sel       = dut_if.wb_sel;
        s.alu_a_sel    = dut_if.alu_a_sel;
        s.alu_b_sel    = dut_if.alu_b_sel;
        s.sub_sra      = dut_if.sub_sra;
        s.halted       = dut_if.halted;
        s.illegal      = dut_if.illegal;
        return s;
    endfunction

    function automatic outs_t base(input logic [2:0] st);
        outs_t e;
        e         = '0;
        e.state   = st;
        e.halted  = (st == ST_HALT);
        e.illegal = exp_illegal;
        return e;
    endfunction

    // Called just after a falling edge with inputs already driven.
    task automatic step(input outs_t e, input string name);
        exp_q.push_back(e);
        #1;
        if (exp_q.size() > 0) begin
            outs_t x = exp_q.pop_front();
            check(name, 64'(sample()), 64'(x));
        end
        @(negedge clk);
    endtask

    task automatic noise();
        dut_if.mem_ready = 1'($urandom_range(0, 1));
        dut_if.start     = 1'($urandom_range(0, 1));
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] i, input int fw, input int mw,
                                input logic t, input kind_e k, input logic il, input logic a,
                                input logic b, input logic s, input logic rf,
                                input logic [1:0] wb, input logic [1:0] pc);
        vec_t v;
        v.name = n; v.insn = i; v.fetch_wait = fw; v.mem_wait = mw; v.taken = t;
        v.kind = k; v.sets_illegal = il; v.alu_a = a; v.alu_b = b; v.sub_sra = s;
        v.rf_we = rf; v.wb_sel = wb; v.pc_src = pc;
        return v;
    endfunction

    task automatic run_insn(input vec_t v);
        outs_t e;
        dut_if.insn = v.insn;
        for (int w = 0; w <= v.fetch_wait; w++) begin
            dut_if.mem_ready    = (w == v.fetch_wait);
            dut_if.start        = 1'($urandom_range(0, 1));
            dut_if.branch_taken = 1'($urandom_range(0, 1));
            e = base(ST_FETCH); e.mem_req = 1'b1; e.ir_we = dut_if.mem_ready;
            step(e, {v.name, "/fetch"});
        end
        noise();
        step(base(ST_DEC), {v.name, "/decode"});
        if (v.kind == K_HALT) begin
            exp_illegal = exp_illegal | v.sets_illegal;
            for (int c = 0; c < 3; c++) begin
                dut_if.mem_ready = 1'($urandom_range(0, 1));
                dut_if.start     = (c == 2);
                step(base(ST_HALT), {v.name, "/halt"});
            end
            dut_if.start = 1'b0;
            return;
        end
        noise();
        dut_if.branch_taken = v.taken;
        e = base(ST_EXEC); e.alu_a_sel = v.alu_a; e.alu_b_sel = v.alu_b; e.sub_sra = v.sub_sra;
        step(e, {v.name, "/exec"});
        dut_if.branch_taken = ~v.taken;
        if (v.kind == K_LOAD || v.kind == K_STORE) begin
            for (int w = 0; w <= v.mem_wait; w++) begin
                dut_if.mem_ready = (w == v.mem_wait);
                dut_if.start     = 1'($urandom_range(0, 1));
                e = base(ST_MEM); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
                e.mem_we = (v.kind == K_STORE);
                e.pc_we  = (v.kind == K_STORE) && dut_if.mem_ready;
                step(e, {v.name, "/mem"});
            end
        end
        if (v.kind != K_STORE) begin
            noise();
            e = base(ST_WB); e.pc_we = 1'b1; e.rf_we = v.rf_we; e.wb_sel = v.wb_sel;
            e.pc_src = v.pc_src; e.sub_sra = v.sub_sra;
            step(e, {v.name, "/wb"});
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        dut_if.mem_ready = 1'b0;
        dut_if.start     = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_illegal = 1'b0;
    endtask

    initial begin
        outs_t e;
        //            name      insn          fw mw tk kind     il a  b  s  rf wb     pc
        vecs[0]  = mk("addi",   32'h00500093, 0, 0, 0, K_ALU,   0, 0, 1, 0, 1, 2'b00, 2'b00);
        vecs[1]  = mk("sub",    32'h402081B3, 0, 0, 0, K_ALU,   0, 0, 0, 1, 1, 2'b00, 2'b00);
        vecs[2]  = mk("srai",   32'h4030D093, 0, 0, 0, K_ALU,   0, 0, 1, 1, 1, 2'b00, 2'b00);
        vecs[3]  = mk("srli",   32'h0030D093, 0, 0, 0, K_ALU,   0, 0, 1, 0, 1, 2'b00, 2'b00);
        vecs[4]  = mk("sltiu",  32'h0010B093, 0, 0, 0, K_ALU,   0, 0, 1, 1, 1, 2'b00, 2'b00);
        vecs[5]  = mk("slt",    32'h0020A1B3, 0, 0, 0, K_ALU,   0, 0, 0, 1, 1, 2'b00, 2'b00);
        vecs[6]  = mk("sra",    32'h4020D1B3, 0, 0, 0, K_ALU,   0, 0, 0, 1, 1, 2'b00, 2'b00);
        vecs[7]  = mk("add_fw", 32'h002081B3, 2, 0, 0, K_ALU,   0, 0, 0, 0, 1, 2'b00, 2'b00);
        vecs[8]  = mk("lw",     32'h0000A283, 0, 2, 0, K_LOAD,  0, 0, 1, 0, 1, 2'b01, 2'b00);
        vecs[9]  = mk("sw",     32'h0020A023, 0, 1, 0, K_STORE, 0, 0, 1, 0, 0, 2'b00, 2'b00);
        vecs[10] = mk("beq_t",  32'h00208463, 0, 0, 1, K_ALU,   0, 1, 1, 1, 0, 2'b00, 2'b01);
        vecs[11] = mk("beq_n",  32'h00208463, 0, 0, 0, K_ALU,   0, 1, 1, 1, 0, 2'b00, 2'b00);
        vecs[12] = mk("jal",    32'h008000EF, 0, 0, 0, K_ALU,   0, 1, 1, 0, 1, 2'b10, 2'b01);
        vecs[13] = mk("jalr",   32'h000080E7, 0, 0, 0, K_ALU,   0, 0, 1, 0, 1, 2'b10, 2'b10);
        vecs[14] = mk("lui",    32'h123450B7, 0, 0, 0, K_ALU,   0, 0, 1, 0, 1, 2'b11, 2'b00);
        vecs[15] = mk("auipc",  32'h00001097, 0, 0, 0, K_ALU,   0, 1, 1, 0, 1, 2'b00, 2'b00);
        vecs[16] = mk("fence",  32'h0FF0000F, 0, 0, 0, K_ALU,   0, 0, 1, 0, 0, 2'b00, 2'b00);
        vecs[17] = mk("illegal",32'h0000007F, 0, 0, 0, K_HALT,  1, 0, 0, 0, 0, 2'b00, 2'b00);
        ecall_v  = mk("ecall",  32'h00000073, 0, 0, 0, K_HALT,  0, 0, 0, 0, 0, 2'b00, 2'b00);

        dut_if.start = 1'b0; dut_if.insn = '0; dut_if.mem_ready = 1'b0; dut_if.branch_taken = 1'b0;
        h_if.start = 1'b0; h_if.insn = '0; h_if.mem_ready = 1'b0; h_if.branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        e = base(ST_FETCH); e.mem_req = 1'b1;
        step(e, "reset_state");

        foreach (vecs[i]) run_insn(vecs[i]);
        run_insn(vecs[0]);

        pulse_reset();
        run_insn(ecall_v);

        // Reset while FETCH waits on memory: the request restarts, no IR load.
        dut_if.insn = vecs[0].insn;
        dut_if.mem_ready = 1'b0;
        e = base(ST_FETCH); e.mem_req = 1'b1;
        step(e, "fetch_wait_pre_reset");
        pulse_reset();
        step(e, "fetch_after_reset");

        // Reset while MEM waits: the data-side request is abandoned.
        dut_if.insn = vecs[8].insn;
        dut_if.mem_ready = 1'b1;
        e = base(ST_FETCH); e.mem_req = 1'b1; e.ir_we = 1'b1;
        step(e, "lw_rst/fetch");
        step(base(ST_DEC), "lw_rst/decode");
        e = base(ST_EXEC); e.alu_b_sel = 1'b1;
        step(e, "lw_rst/exec");
        dut_if.mem_ready = 1'b0;
        e = base(ST_MEM); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
        step(e, "lw_rst/mem_wait");
        pulse_reset();
        e = base(ST_FETCH); e.mem_req = 1'b1;
        step(e, "mem_after_reset");

        // Instance that leaves reset in HALT.
        reset_h = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("h_reset_state", 64'(h_if.state), 64'(ST_HALT));
            check("h_reset_halted", 64'(h_if.halted), 64'd1);
            check("h_reset_mem_req", 64'(h_if.mem_req), 64'd0);
            @(negedge clk);
        end
        h_if.start = 1'b1;
        #1 check("h_start_cycle_state", 64'(h_if.state), 64'(ST_HALT));
        @(negedge clk);
        h_if.start = 1'b0;
        #1;
        check("h_after_start_state", 64'(h_if.state), 64'(ST_FETCH));
        check("h_after_start_mem_req", 64'(h_if.mem_req), 64'd1);
        check("h_after_start_halted", 64'(h_if.halted), 64'd0);
        @(negedge clk);
        reset_h = 1'b1;
        @(negedge clk);
        reset_h = 1'b0;
        #1;
        check("h_rst_in_fetch_state", 64'(h_if.state), 64'(ST_HALT));
        check("h_rst_in_fetch_mem_req", 64'(h_if.mem_req), 64'd0);
        check("h_illegal", 64'(h_if.illegal), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
